// File: rtl/route_step_sched.sv
// route_step_sched: buffers 16-bit route words from the UART wrapper and issues
// their 2-bit veer steps (LSB pair first) to the navigation controller.
// A 00 step ends the route; abort flushes the queue and the in-flight word.
module route_step_sched #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [15:0]            cmd,
  input  logic                   cmd_rdy,
  output logic                   clr_cmd_rdy,
  input  logic                   step_rdy,
  input  logic                   abort,
  output logic [1:0]             step,
  output logic                   step_vld,
  output logic                   route_done,
  output logic                   aborted,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_cnt,
  output logic [3:0]             steps_left
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoad  = 2'd1,
    StIssue = 2'd2,
    StDone  = 2'd3
  } state_t;

  state_t        state;
  logic [15:0]   shifter;
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  // Fullness uses the occupancy at the start of the cycle, so a pop in the
  // same cycle does not make room for a push until the next cycle.
  assign push        = cmd_rdy && (fifo_cnt < FULL_CNT) && !abort;
  assign pop         = (state == StLoad) && (fifo_cnt != '0) && !abort;
  assign clr_cmd_rdy = push;

  // Outputs decoded purely from registered state (Moore style)
  assign step_vld   = (state == StIssue) && (shifter[1:0] != 2'b00);
  assign step       = step_vld ? shifter[1:0] : 2'b00;
  assign route_done = (state == StDone);
  assign busy       = (state != StIdle);

  // Word storage; contents need no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= cmd;
    end
  end

  // FIFO pointers and occupancy; abort empties the queue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else if (abort) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Route FSM: load words, shift out steps on handshake, end on a 00 step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= StIdle;
      shifter    <= '0;
      steps_left <= '0;
      aborted    <= 1'b0;
    end else begin
      aborted <= abort;
      if (abort) begin
        // A step_rdy in this cycle is dropped along with the route
        state      <= StIdle;
        shifter    <= '0;
        steps_left <= '0;
      end else begin
        unique case (state)
          StIdle: begin
            if (fifo_cnt != '0) begin
              state <= StLoad;
            end
          end
          StLoad: begin
            // Route spans words; an empty queue just waits here
            if (pop) begin
              shifter    <= mem[rd_ptr];
              steps_left <= 4'd8;
              state      <= StIssue;
            end
          end
          StIssue: begin
            if (shifter[1:0] == 2'b00) begin
              // End marker: rest of this word is discarded
              state <= StDone;
            end else if (step_rdy) begin
              shifter    <= {2'b00, shifter[15:2]};
              steps_left <= steps_left - 4'd1;
              if (steps_left == 4'd1) begin
                state <= StLoad;
              end
            end
          end
          StDone: begin
            shifter    <= '0;
            steps_left <= '0;
            state      <= StIdle;
          end
          default: begin
            state <= StIdle;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_route_step_sched.sv
// Directed bench for route_step_sched: cycle tables for plain routes plus
// hand-written sequences for backpressure, full FIFO, abort and reset.
module tb_route_step_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        step_rdy;
  logic        abort;
  logic [1:0]  step;
  logic        step_vld;
  logic        route_done;
  logic        aborted;
  logic        busy;
  logic [2:0]  fifo_cnt;
  logic [3:0]  steps_left;

  int n_vec = 0;
  int n_err = 0;

  route_step_sched #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd        (cmd),
    .cmd_rdy    (cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy),
    .step_rdy   (step_rdy),
    .abort      (abort),
    .step       (step),
    .step_vld   (step_vld),
    .route_done (route_done),
    .aborted    (aborted),
    .busy       (busy),
    .fifo_cnt   (fifo_cnt),
    .steps_left (steps_left)
  );

  always #5 clk = ~clk;

  // Observed bundle: {vld, step, done, busy, clr, cnt[2:0], steps_left[3:0], aborted}
  typedef struct {
    logic        cmd_rdy;
    logic [15:0] cmd;
    logic        step_rdy;
    logic [13:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [13:0] obs();
    return {step_vld, step, route_done, busy, clr_cmd_rdy, fifo_cnt, steps_left, aborted};
  endfunction

  task automatic add(input logic cr, input logic [15:0] c, input logic sr,
                     input logic vld, input logic [1:0] stp, input logic dn,
                     input logic bsy, input logic clr, input logic [2:0] cnt,
                     input logic [3:0] sl);
    vec_t v;
    v.cmd_rdy  = cr;
    v.cmd      = c;
    v.step_rdy = sr;
    v.exp      = {vld, stp, dn, bsy, clr, cnt, sl, 1'b0};
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n    = 1'b0;
    cmd      = '0;
    cmd_rdy  = 1'b0;
    step_rdy = 1'b0;
    abort    = 1'b0;

    // Single word 0x0009: steps 01, 10, then end marker
    add(1, 16'h0009, 1, 0, 2'd0, 0, 0, 1, 3'd0, 4'd0);
    add(0, 16'h0000, 1, 0, 2'd0, 0, 0, 0, 3'd1, 4'd0);
    add(0, 16'h0000, 1, 0, 2'd0, 0, 1, 0, 3'd1, 4'd0);
    add(0, 16'h0000, 1, 1, 2'd1, 0, 1, 0, 3'd0, 4'd8);
    add(0, 16'h0000, 1, 1, 2'd2, 0, 1, 0, 3'd0, 4'd7);
    add(0, 16'h0000, 1, 0, 2'd0, 0, 1, 0, 3'd0, 4'd6);
    add(0, 16'h0000, 1, 0, 2'd0, 1, 1, 0, 3'd0, 4'd6);
    add(0, 16'h0000, 1, 0, 2'd0, 0, 0, 0, 3'd0, 4'd0);
    // Two words 0xAAAA then 0x0001: eight 10 steps, LOAD gap, one 01, done
    add(1, 16'hAAAA, 1, 0, 2'd0, 0, 0, 1, 3'd0, 4'd0);
    add(1, 16'h0001, 1, 0, 2'd0, 0, 0, 1, 3'd1, 4'd0);
    add(0, 16'h0000, 1, 0, 2'd0, 0, 1, 0, 3'd2, 4'd0);
    for (int i = 0; i < 8; i++) begin
      add(0, 16'h0000, 1, 1, 2'd2, 0, 1, 0, 3'd1, 4'(8 - i));
    end
    add(0, 16'h0000, 1, 0, 2'd0, 0, 1, 0, 3'd1, 4'd0);
    add(0, 16'h0000, 1, 1, 2'd1, 0, 1, 0, 3'd0, 4'd8);
    add(0, 16'h0000, 1, 0, 2'd0, 0, 1, 0, 3'd0, 4'd7);
    add(0, 16'h0000, 1, 0, 2'd0, 1, 1, 0, 3'd0, 4'd7);
    add(0, 16'h0000, 1, 0, 2'd0, 0, 0, 0, 3'd0, 4'd0);

    // Reset state
    #2;
    chk("reset_outputs", 32'(obs()), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Table-driven routes
    foreach (vecs[i]) begin
      cmd_rdy  = vecs[i].cmd_rdy;
      cmd      = vecs[i].cmd;
      step_rdy = vecs[i].step_rdy;
      #1;
      chk($sformatf("vec%0d", i), 32'(obs()), 32'(vecs[i].exp));
      tick();
    end
    cmd_rdy  = 1'b0;
    step_rdy = 1'b0;

    // Backpressure: word 0x0003 held for 20 cycles, then one accept ends the route
    cmd_rdy = 1'b1;
    cmd     = 16'h0003;
    #1;
    chk("bp_push", 32'(clr_cmd_rdy), 32'h1);
    tick();
    cmd_rdy = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("bp_hold%0d", i), 32'({step_vld, step}), 32'b111);
      tick();
    end
    step_rdy = 1'b1;
    #1;
    chk("bp_accept", 32'({step_vld, step}), 32'b111);
    tick();
    step_rdy = 1'b0;
    #1;
    chk("bp_marker_vld", 32'(step_vld), 32'h0);
    tick();
    chk("bp_done", 32'({route_done, busy}), 32'b11);
    tick();
    chk("bp_idle", 32'({route_done, busy}), 32'b00);

    // FIFO full: one word in the shifter, four queued, a fifth left pending
    cmd_rdy = 1'b1;
    cmd     = 16'h5555;
    #1;
    chk("ff_push0", 32'(clr_cmd_rdy), 32'h1);
    tick();
    cmd = 16'h1111;
    #1;
    chk("ff_push1", 32'(clr_cmd_rdy), 32'h1);
    tick();
    cmd = 16'h2222;
    #1;
    chk("ff_push2", 32'(clr_cmd_rdy), 32'h1);
    tick();
    cmd = 16'h3333;
    #1;
    chk("ff_push3", 32'({clr_cmd_rdy, fifo_cnt}), 32'b1_010);
    tick();
    cmd = 16'h4444;
    #1;
    chk("ff_push4", 32'({clr_cmd_rdy, fifo_cnt}), 32'b1_011);
    tick();
    cmd = 16'h6666;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("ff_full%0d", i), 32'({clr_cmd_rdy, fifo_cnt, step_vld, step}),
          32'b0_100_1_01);
      tick();
    end
    step_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("ff_drain%0d", i), 32'({step_vld, step}), 32'b1_01);
      tick();
    end
    step_rdy = 1'b0;
    #1;
    chk("ff_pop_cycle", 32'({clr_cmd_rdy, fifo_cnt, step_vld, busy}), 32'b0_100_0_1);
    tick();
    chk("ff_late_push", 32'({clr_cmd_rdy, fifo_cnt, step_vld, step}), 32'b1_011_1_01);
    tick();
    cmd_rdy = 1'b0;
    #1;
    chk("ff_refilled", 32'(fifo_cnt), 32'h4);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    #1;
    chk("ff_flush", 32'({fifo_cnt, busy, aborted}), 32'b000_0_1);
    tick();

    // Abort mid-route with three words queued and a coincident step_rdy
    cmd_rdy = 1'b1;
    cmd     = 16'h5555;
    tick();
    cmd = 16'h6666;
    tick();
    cmd = 16'h7777;
    tick();
    cmd = 16'h8888;
    tick();
    cmd      = 16'h000E;
    abort    = 1'b1;
    step_rdy = 1'b1;
    #1;
    chk("ab_pre", 32'({step_vld, step, fifo_cnt, clr_cmd_rdy}), 32'b1_01_011_0);
    tick();
    abort    = 1'b0;
    step_rdy = 1'b0;
    #1;
    chk("ab_after", 32'({fifo_cnt, steps_left, step_vld, aborted, busy, clr_cmd_rdy}),
        32'b000_0000_0_1_0_1);
    tick();
    cmd_rdy = 1'b0;
    #1;
    chk("ab_new_word", 32'({fifo_cnt, aborted}), 32'b001_0);
    tick();
    tick();
    step_rdy = 1'b1;
    #1;
    chk("ab_new_step0", 32'({step_vld, step, steps_left}), 32'b1_10_1000);
    tick();
    chk("ab_new_step1", 32'({step_vld, step}), 32'b1_11);
    tick();
    tick();
    chk("ab_new_done", 32'(route_done), 32'h1);
    step_rdy = 1'b0;
    tick();

    // Reset mid-ISSUE with two words queued
    cmd_rdy = 1'b1;
    cmd     = 16'h5555;
    tick();
    cmd = 16'h1111;
    tick();
    cmd = 16'h2222;
    tick();
    cmd_rdy = 1'b0;
    #1;
    chk("rst_pre", 32'({step_vld, fifo_cnt}), 32'b1_010);
    step_rdy = 1'b1;
    rst_n    = 1'b0;
    #1;
    chk("rst_immediate", 32'(obs()), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("rst_quiet%0d", i), 32'({route_done, busy, fifo_cnt, step_vld}), 32'h0);
      tick();
    end
    step_rdy = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
